// File: rtl/cbus_router.sv
// cbus_router: one CBus master fanned out to NUM_SLAVES slaves.
// Each request is decoded against a base/mask table. The chosen slave is
// locked for the whole burst. A request that hits no slave is answered
// internally with error beats, so the master always gets its last beat.
module cbus_router #(
  parameter int                     NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*64-1:0] SLAVE_BASE = {64'h8000_0000, 64'h0},
  parameter logic [NUM_SLAVES*64-1:0] SLAVE_MASK = {64'hFFFF_FFFF_8000_0000,
                                                    64'hFFFF_FFFF_8000_0000},
  parameter logic [63:0]            ERR_DATA   = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m_valid,
  input  logic [63:0]                m_addr,
  input  logic [2:0]                 m_size,
  input  logic [1:0]                 m_burst,
  input  logic [7:0]                 m_len,
  input  logic [7:0]                 m_wstrobe,
  input  logic [63:0]                m_wdata,
  output logic [63:0]                m_rdata,
  output logic                       m_ready,
  output logic                       m_last,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [63:0]                s_addr,
  output logic [2:0]                 s_size,
  output logic [1:0]                 s_burst,
  output logic [7:0]                 s_len,
  output logic [7:0]                 s_wstrobe,
  output logic [63:0]                s_wdata,
  input  logic [NUM_SLAVES*64-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES-1:0]      s_last,
  output logic [15:0]                err_count
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ROUTE, ERROR} state_t;

  state_t           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [7:0]       cnt_q;
  logic [7:0]       len_q;
  logic [15:0]      err_count_q;

  logic             hit_any;
  logic [SEL_W-1:0] win;
  logic [63:0]      sel_rdata;
  logic             sel_ready;
  logic             sel_last;

  // The error counter holds at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Request fields go to every slave; only s_valid is per-slave.
  assign s_addr    = m_addr;
  assign s_size    = m_size;
  assign s_burst   = m_burst;
  assign s_len     = m_len;
  assign s_wstrobe = m_wstrobe;
  assign s_wdata   = m_wdata;
  assign err_count = err_count_q;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_any = 1'b0;
    win     = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[i*64 +: 64]) == SLAVE_BASE[i*64 +: 64]) begin
        hit_any = 1'b1;
        win     = SEL_W'(i);
      end
    end
  end

  // Select the locked slave's response; other slaves are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_rdata = s_rdata[i*64 +: 64];
        sel_ready = s_ready[i];
        sel_last  = s_last[i];
      end
    end
  end

  // Master response and slave valids, driven from the current state.
  always_comb begin
    s_valid = '0;
    m_rdata = '0;
    m_ready = 1'b0;
    m_last  = 1'b0;
    case (state_q)
      ROUTE: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          s_valid[i] = m_valid && (sel_q == SEL_W'(i));
        end
        m_rdata = sel_rdata;
        m_ready = sel_ready;
        m_last  = sel_last;
      end
      ERROR: begin
        m_rdata = ERR_DATA;
        m_ready = m_valid;
        m_last  = m_valid && (cnt_q == len_q);
      end
      default: ;
    endcase
  end

  // Routing FSM: latch slave and length on leaving IDLE, count error beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      err_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_valid) begin
            sel_q <= win;
            len_q <= m_len;
            cnt_q <= '0;
            if (hit_any) begin
              state_q <= ROUTE;
            end else begin
              state_q     <= ERROR;
              err_count_q <= sat_inc16(err_count_q);
            end
          end
        end
        ROUTE: begin
          if (!m_valid || (sel_ready && sel_last)) begin
            state_q <= IDLE;
          end
        end
        ERROR: begin
          if (!m_valid || (cnt_q == len_q)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_router.sv
// Bench for cbus_router: a scripted slave model feeds responses, and the
// expected master beats are queued when each request is issued.
module tb_cbus_router;

  localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] P0  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] P1  = 64'h2222_2222_2222_2222;
  localparam logic [63:0] Q0  = 64'hAAAA_0000_AAAA_0000;
  localparam logic [63:0] Q1  = 64'hBBBB_1111_BBBB_1111;
  localparam logic [63:0] Q2  = 64'hCCCC_2222_CCCC_2222;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // two-slave instance
  logic         m_valid;
  logic [63:0]  m_addr, m_wdata, m_rdata;
  logic [2:0]   m_size;
  logic [1:0]   m_burst;
  logic [7:0]   m_len, m_wstrobe;
  logic         m_ready, m_last;
  logic [1:0]   s_valid, s_ready, s_last;
  logic [63:0]  s_addr, s_wdata;
  logic [2:0]   s_size;
  logic [1:0]   s_burst;
  logic [7:0]   s_len, s_wstrobe;
  logic [127:0] s_rdata;
  logic [15:0]  err_count;

  // three-slave instance with an overlapping decode table
  logic         t_m_valid;
  logic [63:0]  t_m_addr, t_m_rdata;
  logic         t_m_ready, t_m_last;
  logic [2:0]   t_s_valid, t_s_ready, t_s_last;
  logic [63:0]  t_s_addr, t_s_wdata;
  logic [2:0]   t_s_size;
  logic [1:0]   t_s_burst;
  logic [7:0]   t_s_len, t_s_wstrobe;
  logic [191:0] t_s_rdata;
  logic [15:0]  t_err_count;

  cbus_router dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_burst(m_burst),
    .m_len(m_len), .m_wstrobe(m_wstrobe), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_last(m_last),
    .s_valid(s_valid), .s_addr(s_addr), .s_size(s_size), .s_burst(s_burst),
    .s_len(s_len), .s_wstrobe(s_wstrobe), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_last(s_last),
    .err_count(err_count)
  );

  cbus_router #(
    .NUM_SLAVES(3),
    .SLAVE_BASE({64'h4000_0000, 64'h4000_0000, 64'h0}),
    .SLAVE_MASK({64'hFFFF_FFFF_C000_0000, 64'hFFFF_FFFF_F000_0000,
                 64'hFFFF_FFFF_C000_0000})
  ) dut3 (
    .clk(clk), .reset(reset),
    .m_valid(t_m_valid), .m_addr(t_m_addr), .m_size(3'd3), .m_burst(2'd1),
    .m_len(8'd0), .m_wstrobe(8'd0), .m_wdata(64'd0),
    .m_rdata(t_m_rdata), .m_ready(t_m_ready), .m_last(t_m_last),
    .s_valid(t_s_valid), .s_addr(t_s_addr), .s_size(t_s_size), .s_burst(t_s_burst),
    .s_len(t_s_len), .s_wstrobe(t_s_wstrobe), .s_wdata(t_s_wdata),
    .s_rdata(t_s_rdata), .s_ready(t_s_ready), .s_last(t_s_last),
    .err_count(t_err_count)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  // Issue one transaction, play the selected slave, score every master beat.
  // slv < 0 means the address is expected to miss.
  task automatic do_txn(input logic [63:0] addr, input logic [7:0] len,
                        input logic [7:0] wstrb, input int lat, input int slv,
                        input bit glitch_len);
    int    wcnt;
    int    beat;
    int    c;
    bit    done;
    beat_t e;
    logic  [1:0] exp_sv;
    logic  exp_rdy;
    wcnt = 0; beat = 0; c = 0; done = 1'b0;
    exp_sv = (slv < 0) ? 2'b00 : ((slv == 0) ? 2'b01 : 2'b10);
    for (int b = 0; b <= int'(len); b++) begin
      e.d = (slv < 0) ? ERR : ((slv == 0) ? P0 : P1);
      e.l = (b == int'(len));
      exp_q.push_back(e);
    end
    @(negedge clk);
    m_valid = 1'b1; m_addr = addr; m_len = len; m_wstrobe = wstrb;
    m_wdata = {$urandom, $urandom}; m_size = 3'd3; m_burst = 2'd1;
    s_ready = 2'b11; s_last = 2'b11;
    #1;
    checks++;
    if (s_valid !== 2'b00 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL decode_cycle: s_valid=%b m_ready=%b expected 00/0", s_valid, m_ready);
    end
    while (!done && c < 50) begin
      @(negedge clk);
      c++;
      if (glitch_len && c == 1) m_len = ~len;
      if (slv >= 0) begin
        s_ready = 2'b11; s_last = 2'b11;
        s_ready[slv] = (wcnt == lat);
        s_last[slv]  = (beat == int'(len));
      end
      #1;
      checks++;
      if (s_valid !== exp_sv) begin
        errors++;
        $display("FAIL s_valid c%0d: got %b expected %b", c, s_valid, exp_sv);
      end
      checks++;
      if (s_addr !== addr || s_wdata !== m_wdata || s_wstrobe !== wstrb) begin
        errors++;
        $display("FAIL broadcast c%0d: addr %h/%h wstrobe %h/%h", c, s_addr, addr, s_wstrobe, wstrb);
      end
      exp_rdy = (slv < 0) ? 1'b1 : (wcnt == lat);
      checks++;
      if (m_ready !== exp_rdy) begin
        errors++;
        $display("FAIL m_ready c%0d: got %b expected %b", c, m_ready, exp_rdy);
      end
      if (m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat c%0d: m_ready with no beat expected", c);
          done = 1'b1;
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (m_rdata !== e.d || m_last !== e.l) begin
            errors++;
            $display("FAIL beat%0d: rdata=%h last=%b expected %h/%b", beat, m_rdata, m_last, e.d, e.l);
          end
          if (e.l) done = 1'b1;
        end
        beat++; wcnt = 0;
      end else begin
        wcnt++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: only %0d beats seen, expected %0d", beat, int'(len) + 1);
      exp_q.delete();
    end
  endtask

  task automatic master_drop();
    @(negedge clk);
    m_valid = 1'b0;
    #1;
    checks++;
    if (s_valid !== 2'b00 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after: s_valid=%b m_ready=%b expected 00/0", s_valid, m_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_valid = 1'b0; m_addr = '0; m_size = '0; m_burst = '0; m_len = '0;
    m_wstrobe = '0; m_wdata = '0; s_ready = '0; s_last = '0;
    s_rdata = {P1, P0};
    t_m_valid = 1'b0; t_m_addr = '0; t_s_ready = 3'b111; t_s_last = 3'b111;
    t_s_rdata = {Q2, Q1, Q0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (m_ready !== 1'b0 || m_last !== 1'b0 || m_rdata !== 64'd0 ||
        s_valid !== 2'b00 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL reset: ready=%b last=%b rdata=%h s_valid=%b err=%0d expected all 0",
               m_ready, m_last, m_rdata, s_valid, err_count);
    end
  endtask

  task automatic test_read();
    do_txn(64'h8000_0010, 8'd0, 8'h00, 2, 1, 1'b0);
    master_drop();
  endtask

  task automatic test_write_burst();
    do_txn(64'h0000_0100, 8'd3, 8'hFF, 0, 0, 1'b0);
    master_drop();
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL write_errcnt: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_miss();
    do_txn(64'hFFFF_FFFF_0000_0000, 8'd2, 8'h00, 0, -1, 1'b1);
    master_drop();
    checks++;
    if (err_count !== 16'd1) begin
      errors++;
      $display("FAIL miss_errcnt: got %0d expected 1", err_count);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_valid = 1'b1; m_addr = 64'h0000_0200; m_len = 8'd7; m_wstrobe = 8'h00;
    s_ready = 2'b11; s_last = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (s_valid !== 2'b01 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_burst: s_valid=%b m_ready=%b expected 01/1", s_valid, m_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (s_valid !== 2'b00 || m_ready !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL after_reset: s_valid=%b m_ready=%b err=%0d expected 00/0/0",
               s_valid, m_ready, err_count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (s_valid !== 2'b01) begin
      errors++;
      $display("FAIL redecode: s_valid=%b expected 01", s_valid);
    end
    @(negedge clk);
    m_valid = 1'b0;
    #1;
    checks++;
    if (s_valid !== 2'b00 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL abort: s_valid=%b err=%0d expected 00/0", s_valid, err_count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: m_ready=%b expected 0", m_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_txn(64'h0000_0040, 8'd1, 8'h00, 1, 0, 1'b0);
    do_txn(64'h8000_0040, 8'd0, 8'h00, 0, 1, 1'b0);
    master_drop();
  endtask

  task automatic test_overlap();
    @(negedge clk);
    t_m_valid = 1'b1; t_m_addr = 64'h4000_0000;
    #1;
    checks++;
    if (t_s_valid !== 3'b000) begin
      errors++;
      $display("FAIL ovl_decode: s_valid=%b expected 000", t_s_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (t_s_valid !== 3'b010 || t_m_ready !== 1'b1 || t_m_last !== 1'b1 || t_m_rdata !== Q1) begin
      errors++;
      $display("FAIL ovl_route: s_valid=%b ready=%b last=%b rdata=%h expected 010/1/1/%h",
               t_s_valid, t_m_ready, t_m_last, t_m_rdata, Q1);
    end
    @(negedge clk);
    t_m_valid = 1'b0;
    #1;
    checks++;
    if (t_s_valid !== 3'b000 || t_err_count !== 16'd0) begin
      errors++;
      $display("FAIL ovl_idle: s_valid=%b err=%0d expected 000/0", t_s_valid, t_err_count);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_burst();
    test_miss();
    test_reset_mid();
    test_back_to_back();
    test_overlap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected beats never seen", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cbus_router.md
Name: cbus_router

Overview:
- Parametrised 1-master to NUM_SLAVES CBus router.
- Replaces the fixed two-way RAM/device crossbar in the SoC top level.
- Decodes each request against a per-slave base/mask table and locks the selected slave for the whole burst.
- Requests that hit no slave complete internally with an error response, so the CPU never hangs.

Parameters:
- NUM_SLAVES, 2, number of slave ports (1..8).
- SLAVE_BASE, {64'h8000_0000, 64'h0}, packed NUM_SLAVES*64 base addresses; index i occupies bits [64i+63:64i].
- SLAVE_MASK, {64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000}, packed NUM_SLAVES*64 decode masks.
- ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, rdata returned on decode-error beats.

Ports:
- clk  in  1  CPU clock.
- reset  in  1  synchronous, active-high reset.
- m_valid  in  1  master request valid; held until final ready&last.
- m_addr  in  64  request address.
- m_size  in  3  beat size.
- m_burst  in  2  burst type.
- m_len  in  8  beats minus one.
- m_wstrobe  in  8  byte write strobes; 0 = read.
- m_wdata  in  64  write data.
- m_rdata  out  64  read data.
- m_ready  out  1  beat accepted/complete.
- m_last  out  1  final beat.
- s_valid  out  NUM_SLAVES  per-slave request valid.
- s_addr, s_size, s_burst, s_len, s_wstrobe, s_wdata  out  64/3/2/8/8/64  request fields, broadcast to all slaves.
- s_rdata  in  NUM_SLAVES*64  per-slave read data.
- s_ready  in  NUM_SLAVES  per-slave ready.
- s_last  in  NUM_SLAVES  per-slave last.
- err_count  out  16  saturating count of decode-error transactions.

Behaviour:
- Reset values (synchronous, active-high):
  - state=IDLE, sel=0, beat counter=0, err_count=0.
  - Outputs: m_ready=0, m_last=0, m_rdata=0, all s_valid=0.
- Decode (combinational on m_addr): hit[i] = ((m_addr & MASK[i]) == BASE[i]). The lowest index wins on multiple hits. No hit = miss.
- States: IDLE, ROUTE, ERROR.
- IDLE:
  - All s_valid=0, m_ready=0.
  - If m_valid: register sel=winning index, then go to ROUTE on a hit or ERROR on a miss. Latency is one cycle; the slave sees s_valid no earlier than the cycle after m_valid rises.
- ROUTE:
  - s_valid[sel]=m_valid; the other s_valid bits are 0.
  - Request fields are passed combinationally.
  - m_rdata/m_ready/m_last = s_rdata[sel]/s_ready[sel]/s_last[sel]. Non-selected slave responses are ignored.
  - On s_ready[sel]&s_last[sel], return to IDLE next cycle. A new request is decoded no earlier than that IDLE cycle; back-to-back transactions cost one bubble.
- ERROR:
  - No s_valid is asserted.
  - Produces m_len+1 beats, one per cycle: m_ready=1, m_rdata=ERR_DATA. Write data is discarded.
  - Internal 8-bit beat counter starts at 0. m_last=1 when counter==latched len. After that beat, return to IDLE.
  - err_count increments by 1 on entry (saturates at 16'hFFFF).
- m_len is latched on leaving IDLE; later changes are ignored.
- Protocol violation: m_valid dropping in ROUTE/ERROR aborts. s_valid falls that same cycle; the state goes to IDLE next cycle; no error count.
- Reset mid-burst: immediate return to IDLE, s_valid=0 the cycle after the reset edge. Any slave is responsible for its own reset.
- NUM_SLAVES=1: sel is a 1-bit constant 0; decode still applies, so misses still error.

Test Plan:
- Read of 0x8000_0010, len=0, slave1 ready after 2 cycles → s_valid=2'b10 from cycle 1; m_rdata=s_rdata[1]; m_ready&m_last after 3 cycles; slave0 never valid.
- Burst write to 0x0000_0100, len=3, wstrobe=8'hFF → s_valid=2'b01 held for 4 accepted beats; return to IDLE one cycle after the 4th beat's last; err_count=0.
- NUM_SLAVES=3, overlapping table (slaves 1 and 2 both hit 0x4000_0000) → slave1 selected.
- Miss at 0xFFFF_FFFF_0000_0000, len=2 → no s_valid; 3 consecutive m_ready cycles with rdata=ERR_DATA; m_last on the 3rd; err_count 0→1.
- Assert reset during beat 2 of a len=7 burst → s_valid=0 and m_ready=0 the next cycle; state IDLE; err_count=0.
- Back-to-back: slave0 read then slave1 read with m_valid held high → exactly one idle cycle between; no cross-slave data leakage (s_rdata[0]=0x1111…, s_rdata[1]=0x2222… checked per beat).
